// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl: steps LUT addresses for a waveform generator, playing
// a configured number of periods at a divided sample rate.
module wave_seq_ctrl #(
   parameter int LUT_SIZE  = 16,
   parameter int DIV_WIDTH = 8,
   parameter int CYC_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [1:0]                  cfg_wave_sel,
   input  logic [DIV_WIDTH-1:0]        cfg_div,
   input  logic [CYC_WIDTH-1:0]        cfg_ncyc,
   input  logic                        stop,
   output logic [1:0]                  wave_sel,
   output logic [$clog2(LUT_SIZE)-1:0] lut_addr,
   output logic                        sample_stb,
   output logic                        busy,
   output logic                        done
);
   localparam int AW = $clog2(LUT_SIZE);
   localparam logic [AW-1:0] ADDR_LAST = AW'(LUT_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_n;
   logic [DIV_WIDTH-1:0] presc, presc_n, div_q;
   logic [CYC_WIDTH-1:0] pcnt, pcnt_n, ncyc_q;
   logic [AW-1:0] addr_n;
   logic accept, presc_end, addr_end, last_period;
   logic ready_n, busy_n, stb_n, done_n;

   assign accept = (state == IDLE) && cfg_valid && cfg_ready;
   assign presc_end = (presc == div_q);
   assign addr_end = (lut_addr == ADDR_LAST);
   assign last_period = (ncyc_q != '0) &&
                        (CYC_WIDTH'(pcnt + 1'b1) == ncyc_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         presc      <= '0;
         pcnt       <= '0;
         div_q      <= '0;
         ncyc_q     <= '0;
         wave_sel   <= '0;
         lut_addr   <= '0;
         cfg_ready  <= 1'b0;
         busy       <= 1'b0;
         sample_stb <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         presc      <= presc_n;
         pcnt       <= pcnt_n;
         lut_addr   <= addr_n;
         cfg_ready  <= ready_n;
         busy       <= busy_n;
         sample_stb <= stb_n;
         done       <= done_n;
         if (accept) begin
            wave_sel <= cfg_wave_sel;
            div_q    <= cfg_div;
            ncyc_q   <= cfg_ncyc;
         end
      end
   end

   // stop has priority over a final-period completion
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (accept) state_n = RUN;
         RUN: begin
            if (stop)
               state_n = IDLE;
            else if (presc_end && addr_end && last_period)
               state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      presc_n = presc;
      pcnt_n  = pcnt;
      addr_n  = lut_addr;
      unique case (state)
         IDLE: begin
            if (accept) begin
               presc_n = '0;
               pcnt_n  = '0;
               addr_n  = '0;
            end
         end
         RUN: begin
            if (stop) begin
               presc_n = '0;
               pcnt_n  = '0;
               addr_n  = '0;
            end else if (presc_end) begin
               presc_n = '0;
               if (!addr_end) begin
                  addr_n = lut_addr + 1'b1;
               end else if (!last_period) begin
                  addr_n = '0;
                  if (pcnt != '1) pcnt_n = pcnt + 1'b1;
               end
            end else begin
               presc_n = presc + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // outputs are registered from the upcoming state
   always_comb begin
      ready_n = (state_n == IDLE);
      busy_n  = (state_n == RUN);
      done_n  = (state_n == DONE);
      stb_n   = busy_n && (presc_n == '0);
   end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb_wave_seq_ctrl: table vectors, directed corner sequences and
// random traffic checked against a cycle-count reference model.
module tb_wave_seq_ctrl;
   localparam int LUT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_valid, cfg_ready, stop;
   logic [1:0] cfg_wave_sel, wave_sel;
   logic [7:0] cfg_div, cfg_ncyc;
   logic [3:0] lut_addr;
   logic       sample_stb, busy, done;

   int tests = 0;
   int fails = 0;

   wave_seq_ctrl #(
      .LUT_SIZE(16), .DIV_WIDTH(8), .CYC_WIDTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_wave_sel(cfg_wave_sel), .cfg_div(cfg_div),
      .cfg_ncyc(cfg_ncyc), .stop(stop),
      .wave_sel(wave_sel), .lut_addr(lut_addr),
      .sample_stb(sample_stb), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // reference model: position in a run is a plain cycle count t
   int    m_mode;
   longint m_t;
   int    m_div, m_ncyc, m_sel, m_addr;
   bit    m_ready;

   task automatic m_reset();
      m_mode = 0; m_t = 0; m_div = 0; m_ncyc = 0;
      m_sel = 0; m_addr = 0; m_ready = 1'b0;
   endtask

   task automatic m_step(input bit v, input bit stp,
                         input int sel, input int dv, input int nc);
      case (m_mode)
         0: if (v && m_ready) begin
            m_mode = 1; m_t = 0;
            m_sel = sel; m_div = dv; m_ncyc = nc;
         end
         1: if (stp) begin
            m_mode = 0; m_addr = 0;
         end else begin
            m_t++;
            if (m_ncyc != 0 &&
                m_t == longint'(m_ncyc) * LUT * (m_div + 1))
               m_mode = 2;
         end
         default: m_mode = 0;
      endcase
      m_ready = (m_mode == 0);
      if (m_mode == 1)
         m_addr = int'((m_t / (m_div + 1)) % LUT);
      else if (m_mode == 2)
         m_addr = LUT - 1;
   endtask

   function automatic logic [9:0] m_vec();
      logic st;
      st = (m_mode == 1) && ((m_t % longint'(m_div + 1)) == 0);
      return {m_ready, m_mode == 1, st, m_mode == 2,
              m_sel[1:0], m_addr[3:0]};
   endfunction

   function automatic logic [9:0] obs();
      return {cfg_ready, busy, sample_stb, done, wave_sel, lut_addr};
   endfunction

   function automatic int bsa(bit b, bit s, int a);
      return b * 32 + s * 16 + a;
   endfunction

   task automatic chk(input string name,
                      input logic [9:0] act, input logic [9:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit v, input bit stp, input int sel,
                      input int dv, input int nc, input string tag);
      cfg_valid = v; stop = stp;
      cfg_wave_sel = 2'(sel);
      cfg_div = 8'(dv);
      cfg_ncyc = 8'(nc);
      @(posedge clk);
      m_step(v, stp, sel, dv, nc);
      #1;
      chk(tag, obs(), m_vec());
   endtask

   // asynchronous reset pulse starting between clock edges
   task automatic pulse_reset();
      cfg_valid = 1'b0; stop = 1'b0;
      #3;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("async_rst", obs(), 10'b0);
      @(posedge clk);
      #1;
      chk("rst_hold", obs(), 10'b0);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit v;
      bit stp;
      int sel;
      int dv;
      int nc;
      logic [9:0] exp;
   } vec_t;

   vec_t tv[12];

   initial begin
      int wraps, nbusy;
      bit anydone, allbusy;
      logic [3:0] prev;

      // {ready, busy, stb, done, wave_sel, lut_addr}
      tv[0]  = '{1'b1, 1'b0, 1, 1, 0, 10'b1000_00_0000};
      tv[1]  = '{1'b1, 1'b1, 1, 1, 0, 10'b0110_01_0000};
      tv[2]  = '{1'b0, 1'b0, 0, 0, 0, 10'b0100_01_0000};
      tv[3]  = '{1'b1, 1'b0, 2, 0, 1, 10'b0110_01_0001};
      tv[4]  = '{1'b0, 1'b0, 0, 0, 0, 10'b0100_01_0001};
      tv[5]  = '{1'b0, 1'b0, 0, 0, 0, 10'b0110_01_0010};
      tv[6]  = '{1'b0, 1'b1, 0, 0, 0, 10'b1000_01_0000};
      tv[7]  = '{1'b0, 1'b0, 0, 0, 0, 10'b1000_01_0000};
      tv[8]  = '{1'b1, 1'b0, 3, 0, 0, 10'b0110_11_0000};
      tv[9]  = '{1'b0, 1'b0, 0, 0, 0, 10'b0110_11_0001};
      tv[10] = '{1'b0, 1'b0, 0, 0, 0, 10'b0110_11_0010};
      tv[11] = '{1'b0, 1'b1, 0, 0, 0, 10'b1000_11_0000};

      cfg_valid = 1'b0; stop = 1'b0;
      cfg_wave_sel = '0; cfg_div = '0; cfg_ncyc = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset", obs(), 10'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         cyc(tv[i].v, tv[i].stp, tv[i].sel, tv[i].dv, tv[i].nc, "vec_m");
         chk($sformatf("vec%0d", i), obs(), tv[i].exp);
      end

      // one period, every cycle a sample
      cyc(1, 0, 2, 0, 1, "t35");
      chk32("t35_s0", bsa(busy, sample_stb, int'(lut_addr)), bsa(1, 1, 0));
      for (int i = 1; i < 16; i++) begin
         cyc(0, 0, 0, 0, 0, "t35");
         chk32("t35_s", bsa(busy, sample_stb, int'(lut_addr)),
               bsa(1, 1, i));
      end
      cyc(0, 0, 0, 0, 0, "t35");
      chk32("t35_done", bsa(busy, sample_stb, int'(done)), bsa(0, 0, 1));
      cyc(0, 0, 0, 0, 0, "t35");
      chk32("t35_ready", bsa(cfg_ready, done, 0), bsa(1, 0, 0));

      // two periods, sample every 4th cycle
      nbusy = 0;
      cyc(1, 0, 0, 3, 2, "t36");
      for (int k = 1; k <= 129; k++) begin
         if (k > 1) cyc(0, 0, 0, 0, 0, "t36");
         nbusy += int'(busy);
         if (k <= 128)
            chk32("t36_run", bsa(busy, sample_stb, int'(lut_addr)),
                  bsa(1, (k - 1) % 4 == 0, ((k - 1) / 4) % 16));
         else
            chk32("t36_done", bsa(busy, done, 0), bsa(0, 1, 0));
      end
      chk32("t36_nbusy", nbusy, 128);
      cyc(0, 0, 0, 0, 0, "t36");

      // continuous play for 100 periods, then stop
      wraps = 0; anydone = 1'b0; allbusy = 1'b1;
      cyc(1, 0, 1, 1, 0, "t37");
      prev = lut_addr;
      for (int k = 0; k < 100 * LUT * 2; k++) begin
         cyc(0, 0, 0, 0, 0, "t37");
         if (prev == 4'd15 && lut_addr == 4'd0) wraps++;
         if (done) anydone = 1'b1;
         if (!busy) allbusy = 1'b0;
         prev = lut_addr;
      end
      chk32("t37_wraps", wraps, 100);
      chk32("t37_nodone", int'(anydone), 0);
      chk32("t37_busy", int'(allbusy), 1);
      cyc(0, 1, 0, 0, 0, "t37");
      chk("t37_stop", obs(), 10'b1000_01_0000);
      cyc(0, 0, 0, 0, 0, "t37");
      chk32("t37_after", int'(done), 0);

      // stop in the cycle of the final wrap
      cyc(1, 0, 0, 0, 1, "t38");
      for (int i = 1; i < 16; i++) cyc(0, 0, 0, 0, 0, "t38");
      chk32("t38_last", int'(lut_addr), 15);
      cyc(0, 1, 0, 0, 0, "t38");
      chk("t38_stop", obs(), 10'b1000_00_0000);
      cyc(0, 0, 0, 0, 0, "t38");
      chk32("t38_nodone", int'(done), 0);

      // request held through a run, taken right after done
      cyc(1, 0, 2, 0, 1, "t39");
      for (int i = 1; i < 16; i++) begin
         cyc(1, 0, 1, 5, 3, "t39");
         chk32("t39_run", bsa(sample_stb, 0, int'(wave_sel) * 16 +
               int'(lut_addr)), bsa(1, 0, 2 * 16 + i));
      end
      cyc(1, 0, 1, 5, 3, "t39");
      chk32("t39_done", int'(done), 1);
      cyc(1, 0, 1, 5, 3, "t39");
      chk32("t39_idle", int'(cfg_ready), 1);
      cyc(1, 0, 1, 5, 3, "t39");
      chk("t39_new", obs(), 10'b0110_01_0000);
      cyc(0, 0, 0, 0, 0, "t39");
      chk("t39_div", obs(), 10'b0100_01_0000);
      cyc(0, 1, 0, 0, 0, "t39");

      // reset mid-run, between edges
      cyc(1, 0, 3, 2, 3, "t40");
      repeat (10) cyc(0, 0, 0, 0, 0, "t40");
      pulse_reset();
      cyc(0, 0, 0, 0, 0, "t40");
      chk("t40_rel", obs(), 10'b1000_00_0000);
      cyc(0, 0, 0, 0, 0, "t40");
      chk32("t40_idle", bsa(busy, done, 0), 0);

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 799) == 0) begin
            pulse_reset();
         end else begin
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 99) < 2,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wave_seq_ctrl.md
WAVE_SEQ_CTRL -- requirements
Module: wave_seq_ctrl

Interface
REQ-001 Parameter LUT_SIZE, default 16, number of LUT entries per waveform period (power of two).
REQ-002 Parameter DIV_WIDTH, default 8, width of the sample-rate divider field.
REQ-003 Parameter CYC_WIDTH, default 8, width of the period-count field.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 cfg_valid  input  1  configuration request.
REQ-007 cfg_ready  output  1  configuration accepted when cfg_valid && cfg_ready.
REQ-008 cfg_wave_sel  input  2  waveform type code: 0 sine, 1 sawtooth, 2 triangular, 3 rectangular.
REQ-009 cfg_div  input  DIV_WIDTH  each sample is held cfg_div+1 clk cycles.
REQ-010 cfg_ncyc  input  CYC_WIDTH  number of full periods to play; 0 = continuous.
REQ-011 stop  input  1  abort request.
REQ-012 wave_sel  output  2  registered waveform type driven to the generator datapath.
REQ-013 lut_addr  output  $clog2(LUT_SIZE)  registered LUT index driven to the datapath.
REQ-014 sample_stb  output  1  one-cycle pulse marking a new lut_addr.
REQ-015 busy  output  1  high while in RUN.
REQ-016 done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 FSM states IDLE, RUN, DONE; all outputs driven from registers.
REQ-018 cfg_ready = 1 only in IDLE; a handshake in IDLE captures cfg_wave_sel, cfg_div, cfg_ncyc and moves to RUN next cycle.
REQ-019 On RUN entry: lut_addr = 0, prescaler = 0, period counter = 0, wave_sel = captured value.
REQ-020 In RUN, prescaler counts 0..div and wraps to 0; sample_stb = 1 in every RUN cycle where prescaler == 0.
REQ-021 Latency: handshake at cycle N -> busy = 1 and sample_stb = 1 with lut_addr = 0 at cycle N+1.
REQ-022 When prescaler == div, lut_addr increments next cycle; LUT_SIZE-1 wraps to 0 and increments the period counter.
REQ-023 If ncyc != 0 and the wrap completes period number ncyc, go to DONE instead of wrapping; lut_addr holds LUT_SIZE-1.
REQ-024 DONE lasts exactly one cycle with done = 1, busy = 0, sample_stb = 0, then IDLE.
REQ-025 ncyc = 0: RUN continues indefinitely; the period counter saturates at its max value and does not wrap.
REQ-026 div = 0: sample_stb is high every RUN cycle and lut_addr advances every cycle.
REQ-027 stop = 1 in RUN: next cycle is IDLE, busy = 0, sample_stb = 0, done stays 0, lut_addr = 0.
REQ-028 stop = 1 in the same cycle as the last-period completion: stop wins, with no done pulse.
REQ-029 stop in IDLE or DONE is ignored; cfg_valid with stop in IDLE is still accepted.
REQ-030 cfg_valid outside IDLE has no effect; new configuration applies only from IDLE.
REQ-031 wave_sel holds its last captured value in IDLE and DONE.

Reset
REQ-032 rst_n low asynchronously forces IDLE, wave_sel = 0, lut_addr = 0, sample_stb = 0, busy = 0, done = 0, cfg_ready = 0 and clears all counters.
REQ-033 cfg_ready rises on the first clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-RUN aborts with no done pulse; after release the block waits in IDLE for a new handshake.

Verification
REQ-035 The bench covers: cfg wave_sel=2, div=0, ncyc=1 -> sample_stb on 16 consecutive cycles with lut_addr 0..15, then done pulse one cycle later, then cfg_ready=1.
REQ-036 The bench covers: div=3, ncyc=2 -> sample_stb every 4th cycle, lut_addr 0..15, 0..15, done at cycle 1+128 after the handshake, busy high for 128 cycles.
REQ-037 The bench covers: ncyc=0, div=1, run for 100 periods -> lut_addr wraps 15->0 each period, no done, busy stays high until stop, then IDLE next cycle with done=0.
REQ-038 The bench covers: stop asserted in the cycle of the final wrap (ncyc=1, div=0) -> no done pulse and IDLE next cycle.
REQ-039 The bench covers: cfg_valid held high during RUN with different fields -> outputs unaffected; the held request is accepted in the first IDLE cycle after done.
REQ-040 The bench covers: rst_n pulsed low mid-RUN between clock edges -> all outputs reach reset values without a clock edge; no done pulse.
